// File: rtl/async_fifo_lvl_pkg.sv
// Shared helpers for the async FIFO family: Gray/binary conversion and parameter legality rules.
package async_fifo_pkg;

   localparam int ADDR_W_MIN = 2;
   localparam int ADDR_W_MAX = 12;
   localparam int SYNC_MIN   = 2;
   localparam int SYNC_MAX   = 4;
   localparam int PTR_W_MAX  = ADDR_W_MAX + 1;

   typedef logic [PTR_W_MAX-1:0] ptr_max_t;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic bit params_legal(input int addr_w, input int sync_stages,
                                       input int afull_lvl, input int aempty_lvl);
      return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) &&
             (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
             (afull_lvl >= 1) && (afull_lvl <= depth_of(addr_w)) &&
             (aempty_lvl >= 0) && (aempty_lvl < depth_of(addr_w));
   endfunction

   // Operands are zero-extended to the widest pointer, so any narrower width converts correctly.
   function automatic ptr_max_t bin2gray(input ptr_max_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_max_t gray2bin(input ptr_max_t g);
      ptr_max_t b;
      b = g;
      for (int i = 1; i < PTR_W_MAX; i++) b = b ^ (g >> i);
      return b;
   endfunction

endpackage

// File: rtl/async_fifo_lvl_if.sv
// Data/handshake bundle of async_fifo_lvl; the FIFO takes the slave view, its user the master view.
interface async_fifo_lvl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [DATA_W-1:0] wdata;
   logic              winc;
   logic              wfull;
   logic              walmost_full;
   logic [ADDR_W:0]   wlevel;
   logic              woverflow;

   logic              rinc;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              rempty;
   logic              ralmost_empty;
   logic [ADDR_W:0]   rlevel;
   logic              runderflow;

   modport master (
      output wdata, winc, rinc,
      input  wfull, walmost_full, wlevel, woverflow,
      input  rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
   );

   modport slave (
      input  wdata, winc, rinc,
      output wfull, walmost_full, wlevel, woverflow,
      output rdata, rvalid, rempty, ralmost_empty, rlevel, runderflow
   );
endinterface

// File: rtl/async_fifo_lvl_sync_stage.sv
// Multi-flop synchroniser for a Gray-coded pointer entering the clk domain.
module fifo_sync_stage #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   // Index 0 is the metastability-catching flop, STAGES-1 the settled output.
   logic [STAGES-1:0][WIDTH-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock Gray-pointer FIFO with per-domain fill levels, almost flags and registered read data.
// Define ASYNC_FIFO_ERR_FLAGS_EN to build the sticky woverflow/runderflow flags.
module async_fifo_lvl
   import async_fifo_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_LVL   = 12,
   parameter int AEMPTY_LVL  = 2
) (
   input  logic            wclk,
   input  logic            wrst,
   input  logic            rclk,
   input  logic            rrst,
   async_fifo_lvl_if.slave bus
);
   localparam int DEPTH = depth_of(ADDR_W);
   localparam int PTR_W = ADDR_W + 1;
   typedef logic [PTR_W-1:0] ptr_t;

   localparam ptr_t FULL_LVL  = ptr_t'(DEPTH);
   localparam ptr_t AF_LVL    = ptr_t'(AFULL_LVL);
   localparam ptr_t AE_LVL    = ptr_t'(AEMPTY_LVL);
   localparam bit   PARAMS_OK = params_legal(ADDR_W, SYNC_STAGES, AFULL_LVL, AEMPTY_LVL);

   assert property (@(posedge wclk) PARAMS_OK);

   function automatic ptr_t to_gray(input ptr_t b);
      return ptr_t'(bin2gray(ptr_max_t'(b)));
   endfunction

   function automatic ptr_t to_bin(input ptr_t g);
      return ptr_t'(gray2bin(ptr_max_t'(g)));
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write domain
   ptr_t r_wbin, r_wgray, r_wlevel;
   logic r_wfull, r_walmost_full;
   ptr_t w_wbin_next, w_wgray_next, w_wq_rgray, w_wq_rbin, w_wlevel_next;
   logic w_waccept;

   // Read domain
   ptr_t r_rbin, r_rgray, r_rlevel;
   logic r_rempty, r_ralmost_empty, r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   ptr_t w_rbin_next, w_rgray_next, w_rq_wgray, w_rq_wbin, w_rlevel_next;
   logic w_raccept;

   fifo_sync_stage #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_r2w (
      .clk (wclk),
      .rst (wrst),
      .i_d (r_rgray),
      .o_q (w_wq_rgray)
   );

   fifo_sync_stage #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync_w2r (
      .clk (rclk),
      .rst (rrst),
      .i_d (r_wgray),
      .o_q (w_rq_wgray)
   );

   // NOTE: every signal is assigned on every path through always_comb, so no latch can be inferred.
   always_comb begin
      w_waccept     = bus.winc & ~r_wfull;
      w_wbin_next   = r_wbin + ptr_t'(w_waccept);
      w_wgray_next  = to_gray(w_wbin_next);
      w_wq_rbin     = to_bin(w_wq_rgray);
      w_wlevel_next = w_wbin_next - w_wq_rbin;
   end

   // NOTE: state uses non-blocking assignments so all flops see pre-edge values, matching hardware.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_wbin         <= '0;
         r_wgray        <= '0;
         r_wlevel       <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
      end else begin
         r_wbin         <= w_wbin_next;
         r_wgray        <= w_wgray_next;
         r_wlevel       <= w_wlevel_next;
         r_wfull        <= (w_wlevel_next == FULL_LVL);
         r_walmost_full <= (w_wlevel_next >= AF_LVL);
      end
   end

   // NOTE: the storage array has no reset; pointers alone decide which words are valid.
   always_ff @(posedge wclk) begin
      if (w_waccept) r_mem[r_wbin[ADDR_W-1:0]] <= bus.wdata;
   end

   always_comb begin
      w_raccept     = bus.rinc & ~r_rempty;
      w_rbin_next   = r_rbin + ptr_t'(w_raccept);
      w_rgray_next  = to_gray(w_rbin_next);
      w_rq_wbin     = to_bin(w_rq_wgray);
      w_rlevel_next = w_rq_wbin - w_rbin_next;
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         r_rbin          <= '0;
         r_rgray         <= '0;
         r_rlevel        <= '0;
         r_rempty        <= 1'b1;
         r_ralmost_empty <= 1'b1;
         r_rvalid        <= 1'b0;
         r_rdata         <= '0;
      end else begin
         r_rbin          <= w_rbin_next;
         r_rgray         <= w_rgray_next;
         r_rlevel        <= w_rlevel_next;
         r_rempty        <= (w_rlevel_next == '0);
         r_ralmost_empty <= (w_rlevel_next <= AE_LVL);
         r_rvalid        <= w_raccept;
         if (w_raccept) r_rdata <= r_mem[r_rbin[ADDR_W-1:0]];
      end
   end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
   logic r_woverflow, r_runderflow;

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)                     r_woverflow <= 1'b0;
      else if (bus.winc && r_wfull) r_woverflow <= 1'b1;
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst)                      r_runderflow <= 1'b0;
      else if (bus.rinc && r_rempty) r_runderflow <= 1'b1;
   end

   assign bus.woverflow  = r_woverflow;
   assign bus.runderflow = r_runderflow;
`else
   assign bus.woverflow  = 1'b0;
   assign bus.runderflow = 1'b0;
`endif

   assign bus.wfull         = r_wfull;
   assign bus.walmost_full  = r_walmost_full;
   assign bus.wlevel        = r_wlevel;
   assign bus.rdata         = r_rdata;
   assign bus.rvalid        = r_rvalid;
   assign bus.rempty        = r_rempty;
   assign bus.ralmost_empty = r_ralmost_empty;
   assign bus.rlevel        = r_rlevel;
endmodule
